// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit holding the architectural HI/LO pair.
// Define MDU_FAST_EN to commit mult/div results at the accept edge with no busy phase.
module mdu_seq #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        IntReq,
    input  logic        D_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYC);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYC);
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Returns {commit_ok, hi, lo}; commit_ok is low only for a divide by zero.
    function automatic logic [64:0] mdu_result(input logic [1:0] f,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        logic signed [63:0] sx64;
        logic signed [63:0] sy64;
        logic [63:0]        prod;
        logic signed [31:0] sdvd;
        logic signed [31:0] sdvs;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic [31:0]        udvs;
        logic               ok;
        logic [63:0]        hl;
        sx64 = {{32{x[31]}}, x};
        sy64 = {{32{y[31]}}, y};
        sdvd = x;
        sdvs = (y == 32'd0) ? 32'sd1 : y;
        udvs = (y == 32'd0) ? 32'd1 : y;
        ok   = 1'b1;
        prod = 64'd0;
        sq   = 32'sd0;
        sr   = 32'sd0;
        hl   = 64'd0;
        case (f)
            2'd0: begin
                prod = sx64 * sy64;
                hl   = prod;
            end
            2'd1: begin
                prod = {32'd0, x} * {32'd0, y};
                hl   = prod;
            end
            2'd2: begin
                sq = sdvd / sdvs;
                sr = sdvd % sdvs;
                hl = {sr, sq};
                ok = (y != 32'd0);
            end
            2'd3: begin
                hl = {x % udvs, x / udvs};
                ok = (y != 32'd0);
            end
            default: begin
                hl = 64'd0;
                ok = 1'b0;
            end
        endcase
        return {ok, hl};
    endfunction

    logic [0:0]  state_r;
    logic [3:0]  cnt_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [31:0] sh_hi_r;
    logic [31:0] sh_lo_r;
    logic        sh_ok_r;
    logic        accept_s;
    logic        is_md_s;
    logic [64:0] res_s;
    logic        stall_s;

    assign busy     = (state_r == ST_BUSY);
    assign hi       = hi_r;
    assign lo       = lo_r;
    assign accept_s = start && !IntReq && !busy && (op <= OP_MTLO);
    assign is_md_s  = (op <= OP_DIVU);

    // Arithmetic result for the operation presented this cycle.
    always_comb begin
        res_s = 65'd0;
        if (is_md_s) begin
            res_s = mdu_result(op[1:0], a, b);
        end else begin
            res_s = 65'd0;
        end
    end

    // Pipeline freeze request; suppressed entirely in the fast build.
    always_comb begin
        stall_s = 1'b0;
`ifdef MDU_FAST_EN
        stall_s = 1'b0;
`else
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = D_md && (busy || (start && is_md_s && !IntReq));
        end
`endif
    end

    assign stall = stall_s;

    // FSM, countdown, shadow capture and HI/LO commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            sh_hi_r <= 32'd0;
            sh_lo_r <= 32'd0;
            sh_ok_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (op == OP_MTHI) begin
                            hi_r <= a;
                        end else if (op == OP_MTLO) begin
                            lo_r <= a;
                        end else begin
`ifdef MDU_FAST_EN
                            if (res_s[64]) begin
                                hi_r <= res_s[63:32];
                                lo_r <= res_s[31:0];
                            end
`else
                            sh_hi_r <= res_s[63:32];
                            sh_lo_r <= res_s[31:0];
                            sh_ok_r <= res_s[64];
                            state_r <= ST_BUSY;
                            cnt_r   <= op[1] ? DIV_CNT : MULT_CNT;
`endif
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == 4'd1) begin
                        if (sh_ok_r) begin
                            hi_r <= sh_hi_r;
                            lo_r <= sh_lo_r;
                        end
                        state_r <= ST_IDLE;
                        cnt_r   <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq in its default (multi-cycle) build.
module tb_mdu_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        IntReq;
    logic        D_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    mdu_seq #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .IntReq (IntReq),
        .D_md   (D_md),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one op for a single edge, then release start.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
    endtask

    // Count busy cycles from the current negedge until busy drops (bounded).
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            step();
        end
    endtask

    int n;
    int n_st;

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        IntReq = 1'b0; D_md = 1'b0;
        @(negedge clk);
        step();
        // Stall must stay low while reset is high, even with a mult request.
        D_md = 1'b1; start = 1'b1; op = 3'd0;
        #1 check("stall_in_reset", {31'd0, stall}, 32'd0);
        step();
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0; start = 1'b0; D_md = 1'b0;
        step();

        // MULT signed: -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_busy0", {31'd0, busy}, 32'd1);
        check("mult_no_bypass", lo, 32'd0);
        wait_idle(n);
        check("mult_cycles", n, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU same operands
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle(n);
        check("multu_cycles", n, 32'd5);
        check("multu_hi", hi, 32'd2);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        issue(3'd3, 32'd7, 32'd2);
        wait_idle(n);
        check("divu_cycles", n, 32'd10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n);
        check("div_negb_lo", lo, 32'hFFFF_FFFD);
        check("div_negb_hi", hi, 32'd1);

        // MTHI / MTLO: immediate write, no busy
        issue(3'd4, 32'h11, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", hi, 32'h11);
        issue(3'd5, 32'h22, 32'd0);
        check("mtlo_lo", lo, 32'h22);

        // Divide by zero keeps HI/LO
        issue(3'd2, 32'd99, 32'd0);
        wait_idle(n);
        check("div0_cycles", n, 32'd10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        // Reserved op has no effect
        issue(3'd6, 32'h77, 32'h77);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        check("rsvd_hi", hi, 32'h11);
        check("rsvd_lo", lo, 32'h22);

        // Stall window and ignored second start
        D_md = 1'b1; start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd6;
        #1 n_st = {31'd0, stall};
        step();
        op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            #1 n_st += {31'd0, stall};
            if (i == 2) start = 1'b0;
            step();
        end
        #1;
        check("stall_cycles", n_st, 32'd6);
        check("stall_after", {31'd0, stall}, 32'd0);
        check("stall_busy_after", {31'd0, busy}, 32'd0);
        check("ignored_hi", hi, 32'd0);
        check("ignored_lo", lo, 32'd30);

        // Start blocked by IntReq
        start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3; IntReq = 1'b1;
        #1 check("intreq_stall", {31'd0, stall}, 32'd0);
        step();
        start = 1'b0; IntReq = 1'b0; D_md = 1'b0;
        check("intreq_busy", {31'd0, busy}, 32'd0);
        check("intreq_lo", lo, 32'd30);

        // IntReq mid-busy does not abort
        issue(3'd0, 32'd7, 32'd6);
        step();
        IntReq = 1'b1;
        step();
        IntReq = 1'b0;
        wait_idle(n);
        check("intreq_mid_cycles", n, 32'd3);
        check("intreq_mid_lo", lo, 32'd42);
        check("intreq_mid_hi", hi, 32'd0);

        // Reset during busy cycle 3 of a divide
        issue(3'd4, 32'h55, 32'd0);
        issue(3'd3, 32'd100, 32'd7);
        step();
        step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("rst_no_commit_hi", hi, 32'd0);
        check("rst_no_commit_lo", lo, 32'd0);
        check("rst_no_commit_busy", {31'd0, busy}, 32'd0);

        // Normal operation after reset
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        check("post_rst_cycles", n, 32'd5);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL: parameter MULT_CYC, default 5, busy cycles for MULT/MULTU (range 1..15).
REQ-002 SHALL: parameter DIV_CYC, default 10, busy cycles for DIV/DIVU (range 1..15).
REQ-003 SHALL: clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL: reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL: start  input  1  E-stage instruction is an MDU op this cycle.
REQ-006 SHALL: op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7 reserved (no effect).
REQ-007 SHALL: a  input  32  rs operand.
REQ-008 SHALL: b  input  32  rt operand.
REQ-009 SHALL: IntReq  input  1  exception/interrupt flush; blocks the E-stage start this cycle.
REQ-010 SHALL: D_md  input  1  D-stage instruction uses the MDU (mult/div/mf/mt).
REQ-011 SHALL: busy  output  1  operation in progress.
REQ-012 SHALL: stall  output  1  freeze F/D and clear DE.
REQ-013 SHALL: hi  output  32  architectural HI.
REQ-014 SHALL: lo  output  32  architectural LO.

Function
REQ-015 SHALL: two states, IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-016 SHALL: "accept" = start && !IntReq && !busy && op<=5.
REQ-017 SHALL: accept of MULT/MULTU/DIV/DIVU in IDLE -> next cycle BUSY, cnt=MULT_CYC or DIV_CYC; product/quotient computed from a,b at accept and held in shadow registers.
REQ-018 SHALL: BUSY decrements cnt every cycle; on the edge where cnt==1, write shadow to hi/lo and enter IDLE; busy high exactly N cycles after the accept edge.
REQ-019 SHALL: MULT signed 64-bit product, MULTU unsigned; hi=bits[63:32], lo=bits[31:0].
REQ-020 SHALL: DIV signed, quotient truncates toward zero, remainder has dividend's sign; lo=quotient, hi=remainder; DIVU unsigned.
REQ-021 SHALL: divide with b==0 still runs DIV_CYC busy cycles and leaves hi/lo unchanged.
REQ-022 SHALL: MTHI/MTLO accepted in IDLE write hi/lo from a at that edge, no BUSY phase.
REQ-023 SHALL: start while busy is ignored (no state change); start with IntReq high is ignored.
REQ-024 SHALL: IntReq while BUSY does not abort; operation completes and commits.
REQ-025 SHALL: stall = D_md && (busy || (start && op<=3 && !IntReq)), combinational.
REQ-026 SHALL: hi/lo outputs are register values (MFHI/MFLO read them directly, no bypass of shadow).

Reset
REQ-027 SHALL: reset forces IDLE, cnt=0, busy=0, hi=0, lo=0, shadow=0 at the next edge, overriding start and an in-flight op.
REQ-028 SHALL: stall is 0 while reset is high.

Configuration
REQ-029 SHALL: macro MDU_FAST_EN defined -> MULT_CYC and DIV_CYC are ignored and all mult/div ops commit at the accept edge (busy never asserts, stall always 0).
REQ-030 SHALL: MDU_FAST_EN undefined -> latencies per REQ-017/018.

Verification
REQ-031 SHALL: MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 SHALL: DIVU a=7, b=2 -> busy 10 cycles, then lo=3, hi=1; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 SHALL: DIV b=0 after MTHI a=0x11, MTLO a=0x22 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
REQ-034 SHALL: MULT accepted, D_md=1 throughout -> stall high on accept cycle and 5 busy cycles, low afterward; second start during busy ignored.
REQ-035 SHALL: start MULT with IntReq=1 -> busy stays 0, hi/lo unchanged; IntReq mid-BUSY -> result still commits.
REQ-036 SHALL: reset asserted at busy cycle 3 of DIV -> next edge busy=0, hi=lo=0, no later commit.
